// File: rtl/pmod_btn_pkg.sv
// Shared types and sizing helpers for the Pmod button reader.
package pmod_btn_pkg;

    localparam int unsigned DEBOUNCE_12MHZ_10MS = 120000;
    localparam int unsigned IDX_MAX_W           = 4;

    typedef struct packed {
        logic                 rel;
        logic [IDX_MAX_W-1:0] idx;
    } evt_t;

    function automatic int unsigned idx_w(input int unsigned n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchronizer followed by a stable-count debounce filter.
module btn_debounce
    import pmod_btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_12MHZ_10MS,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o
);

    localparam int unsigned     CW      = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          raw;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign raw     = s2_q ^ ACTIVE_LOW;
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (raw == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = raw;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sync flops reset to the idle pin level so leaving reset is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= ACTIVE_LOW;
            s2_q    <= ACTIVE_LOW;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pmod_btn_reader.sv
// Debounced Pmod button reader with press pulses and a FWFT press/release event FIFO.
module pmod_btn_reader
    import pmod_btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_12MHZ_10MS,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         pmodbtn,
    output logic [N_BTN-1:0]         btn_state,
    output logic [N_BTN-1:0]         press_pulse,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [idx_w(N_BTN):0]    evt_data,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned IDX_W = idx_w(N_BTN);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin_i  (pmodbtn[i]),
            .level_o(btn_state[i])
        );
    end

    logic [N_BTN-1:0] state_prev_q;
    logic [N_BTN-1:0] press_pulse_q, press_pulse_d;
    logic [N_BTN-1:0] pend_v_q, pend_v_d;
    logic [N_BTN-1:0] pend_rel_q, pend_rel_d;
    logic             overflow_q, overflow_d;
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    evt_t             mem_q [FIFO_DEPTH];
    evt_t             mem_d [FIFO_DEPTH];

    logic [N_BTN-1:0] chg, drain_oh, pend_left;
    logic [IDX_W-1:0] drain_idx;
    logic             drain_hit, full, empty, pop, push, ovf_set;
    evt_t             push_evt, head;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign pop   = !empty && evt_ready;
    assign head  = mem_q[rptr_q[AW-1:0]];

    assign evt_valid   = !empty;
    assign evt_data    = empty ? '0 : {head.rel, IDX_W'(head.idx)};
    assign press_pulse = press_pulse_q;
    assign overflow    = overflow_q;

    always_comb begin
        drain_hit = 1'b0;
        drain_idx = '0;
        drain_oh  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (pend_v_q[i] && !drain_hit) begin
                drain_hit   = 1'b1;
                drain_idx   = IDX_W'(i);
                drain_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        chg           = btn_state ^ state_prev_q;
        press_pulse_d = btn_state & ~state_prev_q;
        push          = drain_hit && (!full || pop);
        push_evt.rel  = pend_rel_q[drain_idx];
        push_evt.idx  = IDX_MAX_W'(drain_idx);

        // A bit drained this cycle is free again, so a fresh edge on it is not a loss.
        pend_left  = pend_v_q & ~(push ? drain_oh : '0);
        ovf_set    = |(chg & pend_left);
        pend_v_d   = pend_left | chg;
        pend_rel_d = (pend_rel_q & ~chg) | (~btn_state & chg);
        overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

        wptr_d = wptr_q + (AW + 1)'(push);
        rptr_d = rptr_q + (AW + 1)'(pop);
        mem_d  = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = push_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_prev_q  <= '0;
            press_pulse_q <= '0;
            pend_v_q      <= '0;
            pend_rel_q    <= '0;
            overflow_q    <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_prev_q  <= btn_state;
            press_pulse_q <= press_pulse_d;
            pend_v_q      <= pend_v_d;
            pend_rel_q    <= pend_rel_d;
            overflow_q    <= overflow_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_q         <= mem_d;
        end
    end

endmodule
